// File: rtl/mem_pkg.sv
// mem_pkg: shared request record and tick-tock constants for the memory request path
package mem_pkg;
    localparam int TT_SLOTS = 2;
    localparam int MEM_ADDR_W = 31;
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] address;
        logic [3:0][15:0] data;
        logic [1:0] move;
        logic secondary;
        logic [2:0] length;
        logic is_byte;
        logic is_write;
    } mem_req_t;
endpackage

// File: rtl/mem_tag_fifo.sv
// mem_tag_fifo: two-entry in-order tag queue with simultaneous push and pop
module mem_tag_fifo
    import mem_pkg::*;
#(
    parameter int W = 2
) (
    input  logic main_clk,
    input  logic main_rst_n,
    input  logic push,
    input  logic pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic empty
);
    logic [W-1:0] mem [TT_SLOTS];
    logic rd, wr;
    logic [1:0] cnt;
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            rd <= 1'b0;
            wr <= 1'b0;
            cnt <= 2'd0;
            for (int i = 0; i < TT_SLOTS; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr <= ~wr;
            end
            if (pop) rd <= ~rd;
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end
    assign head = mem[rd];
    assign empty = cnt == 2'd0;
endmodule

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: round-robin sharing of the tick-tock request slots with in-order completion routing
module mem_request_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W = 2
) (
    input  logic main_clk,
    input  logic main_rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [MEM_ADDR_W-1:0] req_address [NUM_REQ],
    input  logic [63:0] req_data [NUM_REQ],
    input  logic [1:0] req_move [NUM_REQ],
    input  logic [NUM_REQ-1:0] req_secondary,
    input  logic [2:0] req_length [NUM_REQ],
    input  logic [NUM_REQ-1:0] req_is_byte,
    input  logic [NUM_REQ-1:0] req_is_write,
    output logic [NUM_REQ-1:0] rsp_valid,
    output logic [127:0] rsp_data,
    output logic [1:0] tick_tock_phase0,
    input  logic [1:0] tick_tock_phase2,
    input  logic tick_tock_phase2_moved,
    input  logic [127:0] cd_access_out_full_data,
    output logic [MEM_ADDR_W-1:0] tt_address [TT_SLOTS],
    output logic [63:0] tt_data_in0,
    output logic [63:0] tt_data_in1,
    output logic [1:0] tt_move [TT_SLOTS],
    output logic [1:0] tt_secondary,
    output logic [2:0] tt_access_length [TT_SLOTS],
    output logic [1:0] tt_is_byte_op,
    output logic [1:0] tt_is_write_op
);
    logic [ID_W-1:0] rr_ptr, gnt, head;
    logic [1:0] occ;
    logic acc, pop, empty;
    mem_req_t req_g;
    mem_req_t slot [TT_SLOTS];
    function automatic logic [ID_W-1:0] wrap(input int v);
        return ID_W'(v >= NUM_REQ ? v - NUM_REQ : v);
    endfunction
    always_comb begin
        gnt = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_valid[wrap(int'(rr_ptr) + k)]) gnt = wrap(int'(rr_ptr) + k);
        occ = tick_tock_phase0 - tick_tock_phase2;
        req_ready = '0;
        req_ready[gnt] = main_rst_n && occ < 2'd2 && req_valid[gnt];
        acc = |req_ready;
        req_g = '{address: req_address[gnt], data: req_data[gnt], move: req_move[gnt],
                  secondary: req_secondary[gnt], length: req_length[gnt],
                  is_byte: req_is_byte[gnt], is_write: req_is_write[gnt]};
        pop = tick_tock_phase2_moved && !empty;
        rsp_valid = '0;
        rsp_valid[head] = pop;
    end
    assign rsp_data = cd_access_out_full_data;
    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            tick_tock_phase0 <= 2'd0;
            rr_ptr <= '0;
            for (int i = 0; i < TT_SLOTS; i++) slot[i] <= '0;
        end else if (acc) begin
            slot[tick_tock_phase0[0]] <= req_g;
            tick_tock_phase0 <= tick_tock_phase0 + 2'd1;
            rr_ptr <= wrap(int'(gnt) + 1);
        end
    end
    always_ff @(posedge main_clk)
        assert (!(main_rst_n && tick_tock_phase2_moved && empty)) else $error("tag fifo underflow");
    mem_tag_fifo #(.W(ID_W)) u_tags (
        .main_clk(main_clk),
        .main_rst_n(main_rst_n),
        .push(acc),
        .pop(pop),
        .din(gnt),
        .head(head),
        .empty(empty)
    );
    for (genvar s = 0; s < TT_SLOTS; s++) begin : g_slot
        assign tt_address[s] = slot[s].address;
        assign tt_move[s] = slot[s].move;
        assign tt_secondary[s] = slot[s].secondary;
        assign tt_access_length[s] = slot[s].length;
        assign tt_is_byte_op[s] = slot[s].is_byte;
        assign tt_is_write_op[s] = slot[s].is_write;
    end
    assign tt_data_in0 = slot[0].data;
    assign tt_data_in1 = slot[1].data;
endmodule

// File: tb/tb_mem_request_arbiter.sv
// tb_mem_request_arbiter: scoreboard bench with a simple tick-tock memory model
module tb_mem_request_arbiter;
    logic main_clk = 1'b0;
    logic main_rst_n;
    logic [2:0] req_valid, req_ready, rsp_valid;
    logic [30:0] req_address [3];
    logic [63:0] req_data [3];
    logic [1:0] req_move [3];
    logic [2:0] req_secondary, req_is_byte, req_is_write;
    logic [2:0] req_length [3];
    logic [127:0] rsp_data, cd_access_out_full_data;
    logic [1:0] tick_tock_phase0, tick_tock_phase2;
    logic tick_tock_phase2_moved;
    logic [30:0] tt_address [2];
    logic [63:0] tt_data_in0, tt_data_in1;
    logic [1:0] tt_move [2];
    logic [1:0] tt_secondary, tt_is_byte_op, tt_is_write_op;
    logic [2:0] tt_access_length [2];

    mem_request_arbiter #(.NUM_REQ(3), .ID_W(2)) dut (
        .main_clk(main_clk), .main_rst_n(main_rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_address(req_address), .req_data(req_data), .req_move(req_move),
        .req_secondary(req_secondary), .req_length(req_length),
        .req_is_byte(req_is_byte), .req_is_write(req_is_write),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tick_tock_phase0(tick_tock_phase0), .tick_tock_phase2(tick_tock_phase2),
        .tick_tock_phase2_moved(tick_tock_phase2_moved),
        .cd_access_out_full_data(cd_access_out_full_data),
        .tt_address(tt_address), .tt_data_in0(tt_data_in0), .tt_data_in1(tt_data_in1),
        .tt_move(tt_move), .tt_secondary(tt_secondary), .tt_access_length(tt_access_length),
        .tt_is_byte_op(tt_is_byte_op), .tt_is_write_op(tt_is_write_op)
    );

    always #5 main_clk = ~main_clk;

    typedef struct {int tag; int c;} ent_t;
    ent_t sb[$];
    int checks = 0, errors = 0, cyc = 0, m_rr = 0, mem_mode = 0;
    int acc_g, acc_s;
    logic pulse = 1'b0;
    logic [1:0] m_ph0 = 2'd0;
    logic [2:0] obs_ready, obs_rsp;

    function automatic logic [102:0] req_bits(int g);
        return {req_address[g], req_data[g], req_move[g], req_secondary[g], req_length[g],
                req_is_byte[g], req_is_write[g]};
    endfunction

    function automatic logic [102:0] slot_bits(int s);
        return {tt_address[s], (s == 0) ? tt_data_in0 : tt_data_in1, tt_move[s], tt_secondary[s],
                tt_access_length[s], tt_is_byte_op[s], tt_is_write_op[s]};
    endfunction

    task automatic rand_req();
        for (int i = 0; i < 3; i++) begin
            req_address[i] = 31'($urandom);
            req_data[i] = {$urandom, $urandom};
            req_move[i] = 2'($urandom);
            req_secondary[i] = 1'($urandom);
            req_length[i] = 3'($urandom);
            req_is_byte[i] = 1'($urandom);
            req_is_write[i] = 1'($urandom);
        end
    endtask

    task automatic cycle();
        int g, s;
        logic [1:0] occ;
        logic [2:0] exp_rdy, exp_rsp;
        logic [102:0] exp_slot;
        logic mv;
        mv = sb.size() > 0 && (pulse || mem_mode == 2 || (mem_mode == 1 && cyc >= sb[0].c + 2));
        pulse = 1'b0;
        tick_tock_phase2_moved = mv;
        cd_access_out_full_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge main_clk);
        g = -1;
        for (int k = 0; k < 3; k++) if (g < 0 && req_valid[(m_rr + k) % 3]) g = (m_rr + k) % 3;
        occ = m_ph0 - tick_tock_phase2;
        exp_rdy = (g >= 0 && occ < 2'd2) ? 3'(1 << g) : 3'b000;
        obs_ready = req_ready;
        obs_rsp = rsp_valid;
        checks++;
        if (req_ready !== exp_rdy) begin errors++; $display("FAIL ready: got %b want %b at cyc %0d", req_ready, exp_rdy, cyc); end
        checks++;
        if (tick_tock_phase0 !== m_ph0) begin errors++; $display("FAIL phase0: got %0d want %0d", tick_tock_phase0, m_ph0); end
        exp_rsp = 3'b000;
        if (mv) begin
            exp_rsp = 3'(1 << sb[0].tag);
            void'(sb.pop_front());
        end
        checks++;
        if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rsp_valid: got %b want %b at cyc %0d", rsp_valid, exp_rsp, cyc); end
        if (exp_rsp != 3'b000) begin
            checks++;
            if (rsp_data !== cd_access_out_full_data) begin errors++; $display("FAIL rsp_data: got %h want %h", rsp_data, cd_access_out_full_data); end
        end
        acc_g = -1;
        s = int'(m_ph0[0]);
        exp_slot = '0;
        if (exp_rdy != 3'b000) begin
            acc_g = g;
            acc_s = s;
            exp_slot = req_bits(g);
            sb.push_back('{g, cyc});
        end
        @(posedge main_clk);
        cyc++;
        #1;
        if (mv) tick_tock_phase2 = tick_tock_phase2 + 2'd1;
        if (acc_g >= 0) begin
            m_ph0 = m_ph0 + 2'd1;
            m_rr = (g + 1) % 3;
            checks++;
            if (slot_bits(s) !== exp_slot) begin errors++; $display("FAIL slot%0d: got %h want %h", s, slot_bits(s), exp_slot); end
        end
    endtask

    task automatic do_reset();
        @(negedge main_clk);
        main_rst_n = 1'b0;
        req_valid = 3'b000;
        tick_tock_phase2_moved = 1'b0;
        tick_tock_phase2 = 2'd0;
        sb.delete();
        m_ph0 = 2'd0;
        m_rr = 0;
        @(negedge main_clk);
        main_rst_n = 1'b1;
        @(posedge main_clk);
        #1;
    endtask

    task automatic test_reset();
        main_rst_n = 1'b0;
        req_valid = 3'b111;
        #12;
        checks++;
        if (tick_tock_phase0 !== 2'd0) begin errors++; $display("FAIL reset_phase0: got %0d want 0", tick_tock_phase0); end
        checks++;
        if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b want 000", req_ready); end
        checks++;
        if (slot_bits(0) !== '0 || slot_bits(1) !== '0) begin errors++; $display("FAIL reset_slots: got %h %h want 0", slot_bits(0), slot_bits(1)); end
        tick_tock_phase2_moved = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 3'b000) begin errors++; $display("FAIL reset_rsp: got %b want 000", rsp_valid); end
        tick_tock_phase2_moved = 1'b0;
        @(negedge main_clk);
        main_rst_n = 1'b1;
        req_valid = 3'b000;
        @(posedge main_clk);
        #1;
    endtask

    task automatic test_single_read();
        int k;
        req_valid = 3'b010;
        req_address[1] = 31'h0000100;
        req_length[1] = 3'd4;
        req_is_write[1] = 1'b0;
        mem_mode = 1;
        cycle();
        checks++;
        if (acc_g != 1 || tt_address[0] !== 31'h0000100 || tick_tock_phase0 !== 2'd1) begin
            errors++; $display("FAIL single_accept: grant %0d addr %h ph0 %0d want 1 100 1", acc_g, tt_address[0], tick_tock_phase0);
        end
        req_valid = 3'b000;
        k = 0;
        do begin cycle(); k++; end while (obs_rsp == 3'b000 && k < 10);
        checks++;
        if (obs_rsp !== 3'b010 || k != 2) begin errors++; $display("FAIL single_rsp: got %b after %0d want 010 after 2", obs_rsp, k); end
    endtask

    task automatic test_contention();
        int glog[$];
        int cnt [3];
        do_reset();
        req_valid = 3'b111;
        mem_mode = 1;
        for (int i = 0; i < 40; i++) begin
            rand_req();
            cycle();
            if (acc_g >= 0) glog.push_back(acc_g);
        end
        checks++;
        if (glog.size() < 12) begin errors++; $display("FAIL contention_count: got %0d want >=12", glog.size()); end
        else begin
            cnt = '{0, 0, 0};
            for (int i = 0; i < 12; i++) begin
                cnt[glog[i]]++;
                checks++;
                if (glog[i] != i % 3) begin errors++; $display("FAIL contention_order: grant %0d got %0d want %0d", i, glog[i], i % 3); end
            end
            checks++;
            if (cnt[0] != 4 || cnt[1] != 4 || cnt[2] != 4) begin errors++; $display("FAIL contention_share: got %0d %0d %0d want 4 4 4", cnt[0], cnt[1], cnt[2]); end
        end
    endtask

    task automatic test_full_stall();
        int n, first_s;
        logic [102:0] snap1;
        do_reset();
        mem_mode = 0;
        req_valid = 3'b001;
        n = 0;
        for (int i = 0; i < 2; i++) begin rand_req(); cycle(); if (acc_g >= 0) n++; end
        checks++;
        if (n != 2) begin errors++; $display("FAIL stall_fill: got %0d accepts want 2", n); end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (obs_ready !== 3'b000) begin errors++; $display("FAIL stall_ready: got %b want 000", obs_ready); end
        end
        snap1 = slot_bits(1);
        pulse = 1'b1;
        cycle();
        n = 0;
        first_s = -1;
        for (int i = 0; i < 5; i++) begin
            rand_req();
            cycle();
            if (acc_g >= 0) begin n++; if (first_s < 0) first_s = acc_s; end
        end
        checks++;
        if (n != 1 || first_s != 0) begin errors++; $display("FAIL stall_reopen: got %0d accepts slot %0d want 1 slot 0", n, first_s); end
        checks++;
        if (slot_bits(1) !== snap1) begin errors++; $display("FAIL stall_slot1: got %h want %h", slot_bits(1), snap1); end
    endtask

    task automatic test_hard_fault();
        logic [102:0] snap0, snap1;
        logic [2:0] rlog[$];
        int k;
        do_reset();
        mem_mode = 0;
        req_valid = 3'b100;
        rand_req();
        cycle();
        req_valid = 3'b001;
        rand_req();
        cycle();
        req_valid = 3'b000;
        snap0 = slot_bits(0);
        snap1 = slot_bits(1);
        for (int i = 0; i < 40; i++) begin
            rand_req();
            cycle();
            checks++;
            if (slot_bits(0) !== snap0 || slot_bits(1) !== snap1) begin
                errors++; $display("FAIL fault_hold: got %h %h want %h %h", slot_bits(0), slot_bits(1), snap0, snap1);
            end
        end
        mem_mode = 1;
        k = 0;
        while (sb.size() > 0 && k < 10) begin
            cycle();
            k++;
            if (obs_rsp != 3'b000) rlog.push_back(obs_rsp);
        end
        checks++;
        if (rlog.size() != 2) begin errors++; $display("FAIL fault_rsp_count: got %0d want 2", rlog.size()); end
        else begin
            checks++;
            if (rlog[0] !== 3'b100 || rlog[1] !== 3'b001) begin errors++; $display("FAIL fault_order: got %b %b want 100 001", rlog[0], rlog[1]); end
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] want;
        do_reset();
        mem_mode = 2;
        req_valid = 3'b001;
        rand_req();
        cycle();
        for (int k = 0; k < 8; k++) begin
            rand_req();
            cycle();
            want = 2'(k + 2);
            checks++;
            if (acc_g != 0 || obs_rsp !== 3'b001) begin errors++; $display("FAIL simul_events: grant %0d rsp %b want 0 001", acc_g, obs_rsp); end
            checks++;
            if (tick_tock_phase0 !== want || 2'(tick_tock_phase0 - tick_tock_phase2) !== 2'd1) begin
                errors++; $display("FAIL simul_count: ph0 %0d ph2 %0d want ph0 %0d occ 1", tick_tock_phase0, tick_tock_phase2, want);
            end
        end
    endtask

    task automatic test_async_reset();
        mem_mode = 1;
        req_valid = 3'b111;
        for (int i = 0; i < 3; i++) begin rand_req(); cycle(); end
        #2;
        main_rst_n = 1'b0;
        tick_tock_phase2_moved = 1'b1;
        #1;
        checks++;
        if (tick_tock_phase0 !== 2'd0 || req_ready !== 3'b000 || rsp_valid !== 3'b000) begin
            errors++; $display("FAIL async_reset: ph0 %0d ready %b rsp %b want 0 000 000", tick_tock_phase0, req_ready, rsp_valid);
        end
        tick_tock_phase2_moved = 1'b0;
        tick_tock_phase2 = 2'd0;
        sb.delete();
        m_ph0 = 2'd0;
        m_rr = 0;
        @(negedge main_clk);
        req_valid = 3'b000;
        main_rst_n = 1'b1;
        @(posedge main_clk);
        #1;
        req_valid = 3'b100;
        rand_req();
        cycle();
        checks++;
        if (acc_g != 2 || acc_s != 0 || tt_address[0] !== req_address[2]) begin
            errors++; $display("FAIL async_first: grant %0d slot %0d addr %h want 2 0 %h", acc_g, acc_s, tt_address[0], req_address[2]);
        end
    endtask

    initial begin
        req_valid = 3'b000;
        tick_tock_phase2 = 2'd0;
        tick_tock_phase2_moved = 1'b0;
        cd_access_out_full_data = '0;
        for (int i = 0; i < 3; i++) begin
            req_address[i] = '0; req_data[i] = '0; req_move[i] = '0; req_length[i] = '0;
        end
        req_secondary = '0;
        req_is_byte = '0;
        req_is_write = '0;
        test_reset();
        test_single_read();
        test_contention();
        test_full_stall();
        test_hard_fault();
        test_simultaneous();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
